// File: rtl/display_row_scan_controller.sv
// Row/bit-plane scan sequencer for a multiplexed LED panel: shift, blank, latch, display.
// Optional ghost blanking (doubled blank with mid-point row switch) via DISPLAY_SCAN_GHOST_BLANK_EN.
module display_row_scan_controller #(
  parameter int bitwidth     = 8,
  parameter int rows         = 16,
  parameter int blank_cycles = 2
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     enable,
  output logic                                     shift_req,
  input  logic                                     shift_done,
  output logic [((rows > 1) ? $clog2(rows) : 1)-1:0]         shift_row,
  output logic [((bitwidth > 1) ? $clog2(bitwidth) : 1)-1:0] shift_plane,
  output logic [((rows > 1) ? $clog2(rows) : 1)-1:0]         row_addr,
  output logic                                     lat,
  output logic                                     oe_n,
  output logic                                     pulse_go,
  input  logic                                     pulse_complete,
  input  logic                                     pulse_full_complete,
  output logic                                     frame_done
);

  localparam int RW = (rows > 1) ? $clog2(rows) : 1;
  localparam int PW = (bitwidth > 1) ? $clog2(bitwidth) : 1;
  localparam int BW = $clog2(2 * blank_cycles + 1);
  localparam logic [RW-1:0] ROW_LAST   = RW'(rows - 1);
  localparam logic [PW-1:0] PLANE_LAST = PW'(bitwidth - 1);
  localparam logic [BW-1:0] BLANK_LAST = BW'(blank_cycles - 1);
`ifdef DISPLAY_SCAN_GHOST_BLANK_EN
  localparam logic [BW-1:0] BLANK_LAST_GHOST = BW'(2 * blank_cycles - 1);
`endif

  typedef enum logic [2:0] {IDLE, SHIFT, BLANK, LATCH, DISPLAY} state_t;

  state_t        state_reg, state_next;
  logic [RW-1:0] row_reg, row_next;
  logic [PW-1:0] plane_reg, plane_next;
  logic [RW-1:0] row_addr_reg, row_addr_next;
  logic [BW-1:0] blank_cnt_reg, blank_cnt_next;
  logic          frame_done_reg, frame_done_next;
`ifdef DISPLAY_SCAN_GHOST_BLANK_EN
  logic          row_change_reg, row_change_next;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      row_reg        <= '0;
      plane_reg      <= '0;
      row_addr_reg   <= '0;
      blank_cnt_reg  <= '0;
      frame_done_reg <= 1'b0;
`ifdef DISPLAY_SCAN_GHOST_BLANK_EN
      row_change_reg <= 1'b0;
`endif
    end else begin
      state_reg      <= state_next;
      row_reg        <= row_next;
      plane_reg      <= plane_next;
      row_addr_reg   <= row_addr_next;
      blank_cnt_reg  <= blank_cnt_next;
      frame_done_reg <= frame_done_next;
`ifdef DISPLAY_SCAN_GHOST_BLANK_EN
      row_change_reg <= row_change_next;
`endif
    end
  end

  always_comb begin
    state_next      = state_reg;
    row_next        = row_reg;
    plane_next      = plane_reg;
    row_addr_next   = row_addr_reg;
    blank_cnt_next  = blank_cnt_reg;
    frame_done_next = 1'b0;
`ifdef DISPLAY_SCAN_GHOST_BLANK_EN
    row_change_next = row_change_reg;
`endif
    shift_req = 1'b0;
    lat       = 1'b0;
    oe_n      = 1'b1;
    pulse_go  = 1'b0;

    case (state_reg)
      IDLE: begin
        if (enable) state_next = SHIFT;
      end
      SHIFT: begin
        shift_req = 1'b1;
        if (shift_done) begin
          state_next     = BLANK;
          blank_cnt_next = '0;
`ifdef DISPLAY_SCAN_GHOST_BLANK_EN
          // A changing row defers the address switch to the middle of a doubled blank.
          row_change_next = (row_reg != row_addr_reg);
          if (row_reg == row_addr_reg) row_addr_next = row_reg;
`else
          row_addr_next = row_reg;
`endif
        end
      end
      BLANK: begin
`ifdef DISPLAY_SCAN_GHOST_BLANK_EN
        if (row_change_reg && blank_cnt_reg == BLANK_LAST) row_addr_next = row_reg;
        if (blank_cnt_reg == (row_change_reg ? BLANK_LAST_GHOST : BLANK_LAST))
          state_next = LATCH;
        else
          blank_cnt_next = blank_cnt_reg + BW'(1);
`else
        if (blank_cnt_reg == BLANK_LAST)
          state_next = LATCH;
        else
          blank_cnt_next = blank_cnt_reg + BW'(1);
`endif
      end
      LATCH: begin
        lat        = 1'b1;
        state_next = DISPLAY;
      end
      DISPLAY: begin
        oe_n     = 1'b0;
        pulse_go = 1'b1;
        if (pulse_complete || pulse_full_complete) begin
          // The pulse generator decides when a row is done; the plane counter only guards overflow.
          if (pulse_full_complete || plane_reg == PLANE_LAST) begin
            plane_next = '0;
            if (row_reg == ROW_LAST) begin
              row_next        = '0;
              frame_done_next = 1'b1;
            end else begin
              row_next = row_reg + RW'(1);
            end
          end else begin
            plane_next = plane_reg + PW'(1);
          end
          state_next = enable ? SHIFT : IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign shift_row   = row_reg;
  assign shift_plane = plane_reg;
  assign row_addr    = row_addr_reg;
  assign frame_done  = frame_done_reg;

endmodule

// File: tb/tb_display_row_scan_controller.sv
// Directed bench for display_row_scan_controller (rows=2, bitwidth=2, blank_cycles=2).
// Honours DISPLAY_SCAN_GHOST_BLANK_EN for the expected blank length on row changes.
module tb_display_row_scan_controller;

  localparam int BITS  = 2;
  localparam int ROWS  = 2;
  localparam int BC    = 2;
  localparam int RW    = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int PW    = (BITS > 1) ? $clog2(BITS) : 1;
`ifdef DISPLAY_SCAN_GHOST_BLANK_EN
  localparam int BLANK_CHG = 2 * BC;
  localparam int IDX_CHG   = BC;
`else
  localparam int BLANK_CHG = BC;
  localparam int IDX_CHG   = 0;
`endif

  logic          clk = 1'b0;
  logic          rst, enable, shift_done, pulse_complete, pulse_full_complete;
  logic          shift_req, lat, oe_n, pulse_go, frame_done;
  logic [RW-1:0] shift_row, row_addr;
  logic [PW-1:0] shift_plane;

  int n_cmp = 0;
  int n_bad = 0;

  display_row_scan_controller #(.bitwidth(BITS), .rows(ROWS), .blank_cycles(BC)) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .shift_req(shift_req), .shift_done(shift_done),
    .shift_row(shift_row), .shift_plane(shift_plane), .row_addr(row_addr),
    .lat(lat), .oe_n(oe_n), .pulse_go(pulse_go),
    .pulse_complete(pulse_complete), .pulse_full_complete(pulse_full_complete),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // From SHIFT: answer with shift_done after 'delay' cycles, then walk BLANK and LATCH into DISPLAY.
  task automatic run_to_display(input int delay, output int blanks, output int addr_idx, output bit ok);
    logic [RW-1:0] start_addr;
    start_addr = row_addr;
    blanks = 0; addr_idx = -1; ok = 1'b0;
    repeat (delay) tick();
    shift_done = 1'b1; tick(); shift_done = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (lat) begin ok = 1'b1; break; end
      if (!oe_n || shift_req) break;
      if (addr_idx < 0 && row_addr !== start_addr) addr_idx = i;
      blanks++;
      tick();
    end
    if (ok) tick();
    $display("plane run: blanks=%0d addr_idx=%0d latched=%0d row_addr=%0d", blanks, addr_idx, ok, row_addr);
  endtask

  task automatic test_reset();
    rst = 1'b1; enable = 1'b0; shift_done = 1'b0; pulse_complete = 1'b0; pulse_full_complete = 1'b0;
    repeat (3) tick();
    n_cmp++; if ({shift_req, lat, pulse_go, frame_done} !== 4'b0000) begin n_bad++; $display("FAIL reset_outs: got %b want 0000", {shift_req, lat, pulse_go, frame_done}); end
    n_cmp++; if (oe_n !== 1'b1) begin n_bad++; $display("FAIL reset_oe_n: got %b want 1", oe_n); end
    n_cmp++; if (row_addr !== '0) begin n_bad++; $display("FAIL reset_row_addr: got %0d want 0", row_addr); end
    rst = 1'b0; tick(); tick();
    n_cmp++; if (shift_req !== 1'b0) begin n_bad++; $display("FAIL idle_hold: shift_req=%b want 0", shift_req); end
    $display("reset done");
  endtask

  task automatic test_first_plane();
    int b, idx; bit ok;
    enable = 1'b1; tick();
    n_cmp++; if ({shift_req, shift_row, shift_plane} !== {1'b1, 1'b0, 1'b0}) begin n_bad++; $display("FAIL first_shift: req/row/plane=%b/%0d/%0d want 1/0/0", shift_req, shift_row, shift_plane); end
    run_to_display(3, b, idx, ok);
    n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL first_latch: latched=%0d want 1", ok); end
    n_cmp++; if (b != BC) begin n_bad++; $display("FAIL first_blank_len: got %0d want %0d", b, BC); end
    n_cmp++; if ({pulse_go, oe_n, lat} !== 3'b100) begin n_bad++; $display("FAIL first_display: go/oe_n/lat=%b want 100", {pulse_go, oe_n, lat}); end
    tick(); tick();
    n_cmp++; if ({pulse_go, oe_n} !== 2'b10) begin n_bad++; $display("FAIL display_hold: go/oe_n=%b want 10", {pulse_go, oe_n}); end
  endtask

  task automatic test_plane_advance();
    int b, idx; bit ok;
    pulse_complete = 1'b1; tick(); pulse_complete = 1'b0;
    n_cmp++; if ({pulse_go, oe_n} !== 2'b01) begin n_bad++; $display("FAIL exit_display: go/oe_n=%b want 01", {pulse_go, oe_n}); end
    n_cmp++; if ({shift_req, shift_row, shift_plane} !== {1'b1, 1'b0, 1'b1}) begin n_bad++; $display("FAIL plane_adv: req/row/plane=%b/%0d/%0d want 1/0/1", shift_req, shift_row, shift_plane); end
    pulse_complete = 1'b1; tick(); pulse_complete = 1'b0;
    n_cmp++; if ({shift_req, shift_plane, pulse_go} !== {1'b1, 1'b1, 1'b0}) begin n_bad++; $display("FAIL ignore_pc_in_shift: req/plane/go=%b/%0d/%b want 1/1/0", shift_req, shift_plane, pulse_go); end
    run_to_display(0, b, idx, ok);
    n_cmp++; if (ok !== 1'b1 || b != BC || idx != -1) begin n_bad++; $display("FAIL plane1_run: ok/blanks/idx=%0d/%0d/%0d want 1/%0d/-1", ok, b, idx, BC); end
  endtask

  task automatic test_plane_wrap();
    int b, idx; bit ok;
    pulse_complete = 1'b1; tick(); pulse_complete = 1'b0;
    n_cmp++; if ({shift_row, shift_plane, frame_done} !== {1'b1, 1'b0, 1'b0}) begin n_bad++; $display("FAIL plane_wrap: row/plane/fd=%0d/%0d/%b want 1/0/0", shift_row, shift_plane, frame_done); end
    run_to_display(1, b, idx, ok);
    n_cmp++; if (ok !== 1'b1 || b != BLANK_CHG) begin n_bad++; $display("FAIL row_change_blank: ok/blanks=%0d/%0d want 1/%0d", ok, b, BLANK_CHG); end
    n_cmp++; if (idx != IDX_CHG) begin n_bad++; $display("FAIL row_addr_timing: idx=%0d want %0d", idx, IDX_CHG); end
    n_cmp++; if (row_addr !== 1'b1) begin n_bad++; $display("FAIL row_addr_row1: got %0d want 1", row_addr); end
  endtask

  task automatic test_frame_wrap();
    int b, idx; bit ok;
    pulse_complete = 1'b1; tick(); pulse_complete = 1'b0;
    n_cmp++; if ({shift_row, shift_plane} !== {1'b1, 1'b1}) begin n_bad++; $display("FAIL row1_plane1: row/plane=%0d/%0d want 1/1", shift_row, shift_plane); end
    run_to_display(0, b, idx, ok);
    n_cmp++; if (ok !== 1'b1 || b != BC || idx != -1) begin n_bad++; $display("FAIL row1p1_run: ok/blanks/idx=%0d/%0d/%0d want 1/%0d/-1", ok, b, idx, BC); end
    pulse_full_complete = 1'b1; tick(); pulse_full_complete = 1'b0;
    n_cmp++; if (frame_done !== 1'b1) begin n_bad++; $display("FAIL frame_done_pulse: got %b want 1", frame_done); end
    n_cmp++; if ({shift_req, shift_row, shift_plane} !== {1'b1, 1'b0, 1'b0}) begin n_bad++; $display("FAIL frame_wrap: req/row/plane=%b/%0d/%0d want 1/0/0", shift_req, shift_row, shift_plane); end
    tick();
    n_cmp++; if (frame_done !== 1'b0) begin n_bad++; $display("FAIL frame_done_width: got %b want 0", frame_done); end
    run_to_display(0, b, idx, ok);
    n_cmp++; if (ok !== 1'b1 || b != BLANK_CHG || row_addr !== 1'b0) begin n_bad++; $display("FAIL wrap_run: ok/blanks/addr=%0d/%0d/%0d want 1/%0d/0", ok, b, row_addr, BLANK_CHG); end
  endtask

  task automatic test_enable_drop();
    enable = 1'b0; tick(); tick();
    n_cmp++; if ({pulse_go, oe_n} !== 2'b10) begin n_bad++; $display("FAIL no_abort: go/oe_n=%b want 10", {pulse_go, oe_n}); end
    pulse_complete = 1'b1; tick(); pulse_complete = 1'b0;
    n_cmp++; if ({shift_req, pulse_go, oe_n} !== 3'b001) begin n_bad++; $display("FAIL to_idle: req/go/oe_n=%b want 001", {shift_req, pulse_go, oe_n}); end
    repeat (3) tick();
    n_cmp++; if ({shift_req, oe_n} !== 2'b01) begin n_bad++; $display("FAIL idle_stay: req/oe_n=%b want 01", {shift_req, oe_n}); end
    enable = 1'b1; tick();
    n_cmp++; if ({shift_req, shift_row, shift_plane} !== {1'b1, 1'b0, 1'b1}) begin n_bad++; $display("FAIL resume: req/row/plane=%b/%0d/%0d want 1/0/1", shift_req, shift_row, shift_plane); end
  endtask

  task automatic test_reset_mid();
    int b, idx; bit ok;
    run_to_display(0, b, idx, ok);
    pulse_complete = 1'b1; tick(); pulse_complete = 1'b0;
    run_to_display(0, b, idx, ok);
    n_cmp++; if (ok !== 1'b1 || pulse_go !== 1'b1 || row_addr !== 1'b1) begin n_bad++; $display("FAIL pre_rst_display: ok/go/addr=%0d/%b/%0d want 1/1/1", ok, pulse_go, row_addr); end
    rst = 1'b1; tick();
    n_cmp++; if ({pulse_go, oe_n, row_addr} !== {1'b0, 1'b1, 1'b0}) begin n_bad++; $display("FAIL rst_mid: go/oe_n/addr=%b/%b/%0d want 0/1/0", pulse_go, oe_n, row_addr); end
    rst = 1'b0; tick();
    n_cmp++; if ({shift_req, shift_row, shift_plane} !== {1'b1, 1'b0, 1'b0}) begin n_bad++; $display("FAIL post_rst: req/row/plane=%b/%0d/%0d want 1/0/0", shift_req, shift_row, shift_plane); end
  endtask

  initial begin
    test_reset();
    test_first_plane();
    test_plane_advance();
    test_plane_wrap();
    test_frame_wrap();
    test_enable_drop();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/display_row_scan_controller.md
DISPLAY_ROW_SCAN_CONTROLLER -- requirements
Module: display_row_scan_controller

Interface
REQ-001 Parameters SHALL be: bitwidth, default 8, bit planes per row; rows, default 16, scanned rows; blank_cycles, default 2, cycles oe_n is held high before each latch.
REQ-002 clk  in  1  clock; all logic SHALL be rising-edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 enable  in  1  scan run request.
REQ-005 shift_req  out  1  request a row/plane shift by the shifter.
REQ-006 shift_done  in  1  shifter finished; one-cycle pulse.
REQ-007 shift_row  out  $clog2(rows)  row to be shifted.
REQ-008 shift_plane  out  $clog2(bitwidth)  bit plane to be shifted; 0 is the MSB.
REQ-009 row_addr  out  $clog2(rows)  panel row address.
REQ-010 lat  out  1  panel latch strobe.
REQ-011 oe_n  out  1  panel output enable, active-low.
REQ-012 pulse_go  out  1  go input of the pulse generator.
REQ-013 pulse_complete  in  1  pulse generator plane complete.
REQ-014 pulse_full_complete  in  1  pulse generator last plane complete.
REQ-015 frame_done  out  1  one-cycle pulse after the last plane of the last row.

Function
REQ-016 The state machine SHALL have the states IDLE, SHIFT, BLANK, LATCH and DISPLAY.
REQ-017 IDLE SHALL move to SHIFT when enable=1; otherwise it SHALL stay in IDLE.
REQ-018 SHIFT:
- shift_req=1; shift_row=row counter; shift_plane=plane counter.
- On shift_done=1 the state SHALL move to BLANK and shift_req SHALL drop the next cycle.
REQ-019 BLANK:
- oe_n=1 for exactly blank_cycles cycles, then the state SHALL move to LATCH.
- row_addr SHALL update to the row counter only on the first BLANK cycle.
REQ-020 LATCH SHALL assert lat=1 for exactly one cycle, then move to DISPLAY.
REQ-021 DISPLAY SHALL drive oe_n=0 and pulse_go=1 until pulse_complete=1 is sampled.
REQ-022 Exit from DISPLAY:
- pulse_go SHALL deassert in the cycle after pulse_complete is sampled.
- oe_n SHALL return to 1 in that same cycle.
REQ-023 Counter update on pulse_complete without pulse_full_complete: plane SHALL increment.
REQ-024 Counter update on pulse_full_complete: plane SHALL go to 0 and row SHALL increment, wrapping rows-1 to 0.
REQ-025 The wrap of row from rows-1 to 0 SHALL pulse frame_done=1 for one cycle.
REQ-026 After DISPLAY the state SHALL go to SHIFT if enable=1, else to IDLE; counters SHALL be retained.
REQ-027 enable deasserting mid-row SHALL NOT abort the row; the current plane SHALL complete first.
REQ-028 shift_done or pulse_complete outside SHIFT or DISPLAY respectively SHALL be ignored.
REQ-029 A plane counter reaching bitwidth-1 without pulse_full_complete SHALL still wrap plane to 0 and advance the row; the generator is authoritative.

Reset
REQ-030 rst SHALL put the state machine in IDLE with row=0 and plane=0.
REQ-031 rst SHALL drive shift_req=0, lat=0, pulse_go=0, frame_done=0, oe_n=1 and row_addr=0.
REQ-032 rst asserted in any state, including mid-DISPLAY, SHALL take effect at the next edge; oe_n=1 SHALL follow within one cycle.

Configuration
REQ-033 The macro DISPLAY_SCAN_GHOST_BLANK_EN SHALL control ghost blanking.
- When defined: on a row change, BLANK SHALL last 2*blank_cycles and row_addr SHALL update at the midpoint of BLANK.
- When undefined: REQ-019 applies unchanged.

Verification
REQ-034 Scenario 1, first row/plane:
- Stimulus: rows=2, bitwidth=2, blank_cycles=2, enable=1, shift_done 3 cycles after shift_req.
- Required: oe_n=1 for 2 cycles, then lat pulses once, then pulse_go=1 with oe_n=0.
REQ-035 Scenario 2, plane advance:
- Stimulus: pulse_complete after the plane 0 display.
- Required: shift_plane=1 with shift_row=0 on the next SHIFT; pulse_go low for at least 1 cycle in between.
REQ-036 Scenario 3, frame wrap:
- Stimulus: pulse_full_complete on row 1.
- Required: frame_done pulses once; the next shift_row=0 and shift_plane=0.
REQ-037 Scenario 4, enable drop:
- Stimulus: enable=0 during DISPLAY.
- Required: the plane finishes; the state is IDLE with oe_n=1; on enable=1 scanning resumes at the retained row/plane.
REQ-038 Scenario 5, reset mid-operation:
- Stimulus: rst during DISPLAY.
- Required: the next cycle shows pulse_go=0, oe_n=1 and row_addr=0.
REQ-039 Scenario 6, ghost blanking:
- Stimulus: DISPLAY_SCAN_GHOST_BLANK_EN defined, change from row 0 to row 1.
- Required: BLANK lasts 4 cycles; row_addr changes after cycle 2.
